// File: rtl/vend_credit_if.sv
// Bus bundle between the credit controller and its three neighbours:
// coin acceptor, item selector and change dispenser.
interface vend_credit_if;
  // Coin acceptor
  logic       coin_valid;
  logic [4:0] coin_val;
  logic       coin_ready;
  logic       coin_reject;
  // Item selector
  logic       vend_req;
  logic [4:0] price;
  logic       vend_ack;
  logic       dispense;
  logic       vend_deny;
  logic       cancel;
  // Change dispenser
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       chg_ready;
  // Status
  logic [4:0] credit;
  logic       busy;

  // Environment side: drives requests, observes controller results
  modport master (
    output coin_valid, coin_val, vend_req, price, cancel, chg_ready,
    input  coin_ready, coin_reject, vend_ack, dispense, vend_deny,
           chg_valid, chg_coin, credit, busy
  );

  // Controller side
  modport slave (
    input  coin_valid, coin_val, vend_req, price, cancel, chg_ready,
    output coin_ready, coin_reject, vend_ack, dispense, vend_deny,
           chg_valid, chg_coin, credit, busy
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending machine credit controller. Owns the customer credit and
// time-shares one 5-bit add/sub datapath between coin insertion,
// purchase deduction and greedy change payout (10 / 5 / 1 units).
module vend_credit_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  vend_credit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ADD, SUB, CHANGE} state_t;

  state_t     state;
  logic [4:0] credit_q;
  logic [4:0] operand_q;     // latched coin value or price
  logic       coin_reject_q;
  logic       vend_ack_q;
  logic       vend_deny_q;

  logic [1:0] denom_code;
  logic [4:0] denom;
  logic       dp_sub;
  logic [4:0] dp_b;
  logic [4:0] dp_res;
  logic       dp_carry;

  // Greedy change denomination, chosen by comparison against the current credit
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    denom_code = 2'b00;
    denom      = 5'd1;
    if (credit_q >= 5'd10) begin
      denom_code = 2'b10;
      denom      = 5'd10;
    end else if (credit_q >= 5'd5) begin
      denom_code = 2'b01;
      denom      = 5'd5;
    end
  end

  // Shared datapath: credit + b when adding, credit + ~b + 1 when subtracting.
  // Carry out means overflow for ADD and "no borrow" for SUB/CHANGE.
  always_comb begin
    dp_sub = (state != ADD);
    dp_b   = (state == CHANGE) ? denom : operand_q;
    {dp_carry, dp_res} = {1'b0, credit_q}
                       + {1'b0, (dp_sub ? ~dp_b : dp_b)}
                       + {5'd0, dp_sub};
  end

  // Control FSM with registered result pulses; a reset aborts any payout in progress
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit_q      <= 5'd0;
      operand_q     <= 5'd0;
      coin_reject_q <= 1'b0;
      vend_ack_q    <= 1'b0;
      vend_deny_q   <= 1'b0;
    end else begin
      coin_reject_q <= 1'b0;
      vend_ack_q    <= 1'b0;
      vend_deny_q   <= 1'b0;
      case (state)
        IDLE: begin
          // Fixed priority: coin > cancel > vend
          if (bus.coin_valid) begin
            operand_q <= bus.coin_val;
            state     <= ADD;
          end else if (bus.cancel) begin
            if (credit_q != 5'd0) state <= CHANGE;
          end else if (bus.vend_req) begin
            operand_q <= bus.price;
            state     <= SUB;
          end
        end
        ADD: begin
          if (dp_carry) coin_reject_q <= 1'b1;
          else          credit_q      <= dp_res;
          state <= IDLE;
        end
        SUB: begin
          if (dp_carry) begin
            credit_q   <= dp_res;
            vend_ack_q <= 1'b1;
            if (dp_res != 5'd0) state <= CHANGE;
            else                state <= IDLE;
          end else begin
            vend_deny_q <= 1'b1;
            state       <= IDLE;
          end
        end
        CHANGE: begin
          if (bus.chg_ready) begin
            credit_q <= dp_res;
            if (dp_res == 5'd0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come from registers or state decode only
  assign bus.coin_ready  = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.chg_valid   = (state == CHANGE);
  assign bus.chg_coin    = (state == CHANGE) ? denom_code : 2'b00;
  assign bus.credit      = credit_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.vend_ack    = vend_ack_q;
  assign bus.dispense    = vend_ack_q;
  assign bus.vend_deny   = vend_deny_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl. A transaction-level model keeps
// the customer credit as a plain integer and derives every expected pulse,
// change coin and credit value from the vending rules.
module tb_vend_credit_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  vend_credit_if bus ();

  vend_credit_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int m_credit    = 0;   // reference model of customer credit

  // Watchdog: never let the run hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Greedy payout rule: biggest of 10/5/1 not exceeding the owed amount
  function automatic int denom_of(input int owed);
    if (owed >= 10) return 10;
    if (owed >= 5)  return 5;
    return 1;
  endfunction

  function automatic logic [1:0] code_of(input int d);
    if (d == 10) return 2'b10;
    if (d == 5)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 5'd0;
    bus.vend_req   = 1'b0;
    bus.price      = 5'd0;
    bus.cancel     = 1'b0;
    bus.chg_ready  = 1'b0;
  endtask

  // Collect change until the model says nothing is owed; controller is expected in CHANGE
  task automatic collect_change(input int stall, input bit rand_ready);
    int   d;
    int   budget;
    logic rdy;
    budget = 0;
    while (m_credit != 0) begin
      d = denom_of(m_credit);
      vectors++;
      if (bus.chg_valid !== 1'b1 || bus.chg_coin !== code_of(d)) begin
        miscompares++;
        $display("FAIL change_coin: chg_valid=%b chg_coin=%b, expected 1/%b (owed %0d)",
                 bus.chg_valid, bus.chg_coin, code_of(d), m_credit);
      end
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if (rand_ready) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      bus.chg_ready = rdy;
      tick();
      if (rdy) m_credit -= d;
      vectors++;
      if (bus.credit !== 5'(m_credit) || bus.vend_ack !== 1'b0 || bus.dispense !== 1'b0) begin
        miscompares++;
        $display("FAIL change_credit: credit=%0d ack=%b dispense=%b, expected %0d/0/0",
                 bus.credit, bus.vend_ack, bus.dispense, m_credit);
      end
      budget++;
      if (budget > 300) begin
        miscompares++;
        $display("FAIL change_timeout: still owed %0d after %0d cycles, expected payout done",
                 m_credit, budget);
        m_credit = 0;
      end
    end
    bus.chg_ready = 1'b0;
    vectors++;
    if (bus.chg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.coin_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL change_end: chg_valid=%b busy=%b coin_ready=%b, expected 0/0/1",
               bus.chg_valid, bus.busy, bus.coin_ready);
    end
  endtask

  // Insert one coin from IDLE and check the ADD cycle and its result
  task automatic do_coin(input logic [4:0] v);
    int sum;
    bit rej;
    sum = m_credit + int'(v);
    rej = (sum > 31);
    vectors++;
    if (bus.coin_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL coin_ready_idle: coin_ready=%b, expected 1", bus.coin_ready);
    end
    bus.coin_valid = 1'b1;
    bus.coin_val   = v;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_val   = 5'($urandom);
    vectors++;
    if (bus.coin_ready !== 1'b0 || bus.busy !== 1'b1 || bus.coin_reject !== 1'b0) begin
      miscompares++;
      $display("FAIL coin_add_cycle: coin_ready=%b busy=%b reject=%b, expected 0/1/0",
               bus.coin_ready, bus.busy, bus.coin_reject);
    end
    tick();
    if (!rej) m_credit = sum;
    vectors++;
    if (bus.coin_reject !== rej || bus.credit !== 5'(m_credit) || bus.coin_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL coin_result: coin=%0d reject=%b credit=%0d ready=%b, expected %b/%0d/1",
               v, bus.coin_reject, bus.credit, bus.coin_ready, rej, m_credit);
    end
  endtask

  // Request one purchase from IDLE, then pay out any change owed
  task automatic do_vend(input logic [4:0] p, input bit rand_ready);
    bit ok;
    ok = (int'(p) <= m_credit);
    bus.vend_req = 1'b1;
    bus.price    = p;
    tick();
    bus.price = 5'($urandom);
    vectors++;
    if (bus.busy !== 1'b1 || bus.vend_ack !== 1'b0 || bus.vend_deny !== 1'b0) begin
      miscompares++;
      $display("FAIL vend_sub_cycle: busy=%b ack=%b deny=%b, expected 1/0/0",
               bus.busy, bus.vend_ack, bus.vend_deny);
    end
    tick();
    bus.vend_req = 1'b0;
    if (ok) m_credit -= int'(p);
    vectors++;
    if (bus.vend_ack !== ok || bus.dispense !== ok || bus.vend_deny !== !ok ||
        bus.credit !== 5'(m_credit) || bus.chg_valid !== (ok && m_credit != 0)) begin
      miscompares++;
      $display("FAIL vend_result: price=%0d ack=%b disp=%b deny=%b credit=%0d chg_valid=%b, expected %b/%b/%b/%0d/%b",
               p, bus.vend_ack, bus.dispense, bus.vend_deny, bus.credit, bus.chg_valid,
               ok, ok, !ok, m_credit, (ok && m_credit != 0));
    end
    if (ok) begin
      collect_change(0, rand_ready);
    end else begin
      tick();
      vectors++;
      if (bus.vend_deny !== 1'b0 || bus.chg_valid !== 1'b0 || bus.credit !== 5'(m_credit)) begin
        miscompares++;
        $display("FAIL vend_deny_after: deny=%b chg_valid=%b credit=%0d, expected 0/0/%0d",
                 bus.vend_deny, bus.chg_valid, bus.credit, m_credit);
      end
    end
  endtask

  // Cancel from IDLE: all credit comes back as change
  task automatic do_cancel(input int stall, input bit rand_ready);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    vectors++;
    if (bus.chg_valid !== (m_credit != 0) || bus.busy !== (m_credit != 0)) begin
      miscompares++;
      $display("FAIL cancel_taken: chg_valid=%b busy=%b, expected %b/%b (credit %0d)",
               bus.chg_valid, bus.busy, (m_credit != 0), (m_credit != 0), m_credit);
    end
    collect_change(stall, rand_ready);
  endtask

  // Power-on reset, then an asynchronous reset in the middle of a payout
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.credit !== 5'd0 || bus.coin_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.chg_valid !== 1'b0 || bus.chg_coin !== 2'b00 || bus.coin_reject !== 1'b0 ||
        bus.vend_ack !== 1'b0 || bus.dispense !== 1'b0 || bus.vend_deny !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: credit=%0d ready=%b busy=%b chg=%b/%b pulses=%b%b%b%b, expected 0/1/0/0/00/0000",
               bus.credit, bus.coin_ready, bus.busy, bus.chg_valid, bus.chg_coin,
               bus.coin_reject, bus.vend_ack, bus.dispense, bus.vend_deny);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_credit = 0;
    tick();

    do_coin(5'd5);
    do_coin(5'd2);
    bus.chg_ready = 1'b0;
    bus.cancel    = 1'b1;
    tick();
    bus.cancel = 1'b0;
    tick();
    vectors++;
    if (bus.chg_valid !== 1'b1 || bus.credit !== 5'd7) begin
      miscompares++;
      $display("FAIL reset_setup: chg_valid=%b credit=%0d, expected 1/7", bus.chg_valid, bus.credit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.credit !== 5'd0 || bus.chg_valid !== 1'b0 || bus.coin_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.chg_coin !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_async: credit=%0d chg_valid=%b ready=%b busy=%b chg_coin=%b, expected 0/0/1/0/00",
               bus.credit, bus.chg_valid, bus.coin_ready, bus.busy, bus.chg_coin);
    end
    m_credit = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Coins 10, 10, 5 back-to-back then a 10 that would overflow
  task automatic test_coins_overflow();
    do_coin(5'd10);
    do_coin(5'd10);
    do_coin(5'd5);
    do_coin(5'd10);
  endtask

  // Credit 25, price 18: approve, then pay 5, 1, 1 with the dispenser always ready
  task automatic test_vend_change();
    do_vend(5'd18, 1'b0);
  endtask

  // Credit 7, price 20: denied, nothing changes
  task automatic test_deny();
    do_coin(5'd7);
    do_vend(5'd20, 1'b0);
  endtask

  // Credit 15, cancel with the dispenser stalled for 4 cycles
  task automatic test_cancel_stall();
    do_coin(5'd8);
    do_cancel(4, 1'b0);
  endtask

  // Coin, cancel and vend all requested in one cycle with zero credit
  task automatic test_priority();
    bus.coin_valid = 1'b1;
    bus.coin_val   = 5'd5;
    bus.cancel     = 1'b1;
    bus.vend_req   = 1'b1;
    bus.price      = 5'd3;
    tick();
    bus.coin_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.chg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_coin_first: busy=%b chg_valid=%b, expected 1/0", bus.busy, bus.chg_valid);
    end
    tick();
    m_credit = 5;
    vectors++;
    if (bus.credit !== 5'd5 || bus.coin_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_coin_credit: credit=%0d ready=%b, expected 5/1", bus.credit, bus.coin_ready);
    end
    tick();
    bus.cancel = 1'b0;
    vectors++;
    if (bus.chg_valid !== 1'b1 || bus.vend_ack !== 1'b0 || bus.vend_deny !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_cancel_taken: chg_valid=%b ack=%b deny=%b, expected 1/0/0",
               bus.chg_valid, bus.vend_ack, bus.vend_deny);
    end
    collect_change(0, 1'b0);
    tick();
    vectors++;
    if (bus.busy !== 1'b1 || bus.chg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_vend_taken: busy=%b chg_valid=%b, expected 1/0", bus.busy, bus.chg_valid);
    end
    tick();
    bus.vend_req = 1'b0;
    vectors++;
    if (bus.vend_deny !== 1'b1 || bus.vend_ack !== 1'b0 || bus.dispense !== 1'b0 || bus.credit !== 5'd0) begin
      miscompares++;
      $display("FAIL prio_vend_denied: deny=%b ack=%b disp=%b credit=%0d, expected 1/0/0/0",
               bus.vend_deny, bus.vend_ack, bus.dispense, bus.credit);
    end
    tick();
  endtask

  // Random mix of coins, purchases and cancels with a randomly stalling dispenser
  task automatic test_random();
    int op;
    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0)      do_coin(5'($urandom_range(0, 31)));
      else if (op < 5)  do_coin(5'($urandom_range(0, 12)));
      else if (op < 8)  do_vend(5'($urandom_range(0, 31)), 1'b1);
      else              do_cancel(int'($urandom_range(0, 2)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_coins_overflow();
    test_vend_change();
    test_deny();
    test_cancel_stall();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

- Sequencing controller for the vending machine's credit register.
- Time-shares one internal 5-bit add/sub datapath (add when sub=0; a + ~b + 1 when sub=1; carry/borrow out) across three jobs: coin insertion, purchase deduction and change payout.
- Sits between the coin acceptor, the item selector and the change dispenser; owns the only copy of customer credit.

## Interface

Parameters:
- none (widths fixed at 5 bits; change denominations fixed at 10, 5 and 1 units)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- coin_valid  in  1  coin offered; accepted when coin_valid & coin_ready
- coin_val  in  5  coin value in units; sampled at acceptance
- coin_ready  out  1  controller can accept a coin (state IDLE)
- coin_reject  out  1  one-cycle pulse: accepted coin would overflow credit; credit unchanged
- vend_req  in  1  level request; held by requester until vend_ack or vend_deny
- price  in  5  item price in units; sampled when the request is taken
- vend_ack  out  1  one-cycle pulse: purchase approved
- dispense  out  1  one-cycle pulse coincident with vend_ack
- vend_deny  out  1  one-cycle pulse: credit < price; credit unchanged
- cancel  in  1  level request: return all credit as change
- chg_valid  out  1  change coin offered
- chg_coin  out  2  00 = 1 unit, 01 = 5 units, 10 = 10 units; 11 is never driven
- chg_ready  in  1  dispenser takes the coin on chg_valid & chg_ready
- credit  out  5  current credit in units
- busy  out  1  state is not IDLE

## Operation

States: IDLE, ADD, SUB, CHANGE.

IDLE
- coin_ready = 1.
- Requests are arbitrated with fixed priority per cycle: coin_valid > cancel > vend_req.
- Coin taken: latch coin_val, go to ADD.
- Cancel taken:
  - credit ≠ 0: go to CHANGE.
  - credit = 0: no-op; stay in IDLE.
- Vend taken: latch price, go to SUB.

ADD (one cycle)
- Datapath computes credit + coin, sub = 0.
- Carry out = 1: pulse coin_reject, credit unchanged.
- Carry out = 0: credit ← sum.
- Always return to IDLE.

SUB (one cycle)
- Datapath computes credit − price, sub = 1.
- carry_borrow = 1 (no borrow):
  - credit ← difference; pulse vend_ack and dispense.
  - Difference ≠ 0: go to CHANGE. Difference = 0: go to IDLE.
- carry_borrow = 0 (borrow): pulse vend_deny, credit unchanged, go to IDLE.
- price = 0 is approved; all credit is then paid as change.

CHANGE
- chg_valid = 1.
- chg_coin is the greedy largest denomination ≤ credit, chosen by comparison: ≥10 gives 10, else ≥5 gives 5, else 1.
- chg_coin stays stable while chg_ready = 0.
- On handshake: credit ← credit − denom through the datapath (sub = 1).
- New credit = 0: go to IDLE. Otherwise stay in CHANGE and present the next coin the following cycle.
- coin_valid, vend_req and cancel are ignored outside IDLE (not lost; they are level signals and are re-sampled in IDLE).

## Timing

Reset values:
- credit = 0, state IDLE.
- coin_ready = 1, busy = 0.
- All pulses = 0; chg_valid = 0; chg_coin = 00.

Reset asserted mid-operation aborts the current operation immediately: credit is cleared and any pending change is forfeited.

Latencies:
- Coin accepted at edge N: credit / coin_reject valid after edge N+1. coin_ready = 0 for exactly one cycle; the next coin can be accepted at edge N+2.
- Vend taken at edge N: vend_ack/vend_deny high during the cycle after edge N+1; credit updated at edge N+1.
- First chg_valid is asserted in that same cycle, when change is owed.

Payout:
- With chg_ready tied high, one change coin per cycle.
- Cancel taken at edge N: chg_valid high from after edge N.

Other rules:
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- credit never wraps: ADD overflow is rejected, SUB underflow is denied, and CHANGE cannot underflow by construction.

## Test plan

- Reset: assert rst_n = 0 mid-CHANGE with credit 7 -> credit = 0, chg_valid = 0, coin_ready = 1 and busy = 0 asynchronously.
- Coins 10, 10, 5 back-to-back, then coin 10 -> credit 25; the fourth coin gives a coin_reject pulse and credit stays 25.
- Credit 25, price 18, chg_ready = 1:
  - vend_ack and dispense pulse; credit 7.
  - chg_coin sequence 01, 00, 00 on consecutive cycles; credit 2, 1, 0; then IDLE.
- Credit 7, price 20 -> vend_deny pulse, credit 7, no dispense, no chg_valid.
- Credit 15, cancel, chg_ready low for 4 cycles -> chg_coin = 10 held stable; credit 5 after the handshake; then 01; credit 0.
- Same-cycle coin 5, cancel and vend_req (price 3) with credit 0:
  - Coin processed first (credit 5).
  - Next IDLE cycle: cancel taken ahead of vend; change 5 paid.
  - Vend is then taken on credit 0 and denied.
